// File: rtl/malloc_buf_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : malloc_pkg
// Description : FSM encoding, default sizes and clogb for the buffer allocator.
// Revision    : 1.0
// ============================================================================
package malloc_pkg;

    localparam int DEF_NUM_BUFS   = 2048;
    localparam int DEF_WORD_WIDTH = 4;
    localparam int DEF_NUM_CH     = 4;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_ARD  = 3'd2,
        ST_ACHK = 3'd3,
        ST_FRD  = 3'd4,
        ST_FWR  = 3'd5
    } state_t;

    // Ceiling log2; clogb(1) == 0.
    function automatic int clogb(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/malloc_buf_alloc_if.sv
`default_nettype none
// ============================================================================
// Interface   : malloc_buf_alloc_if
// Description : Allocation / return / status bundle of the buffer allocator.
// Revision    : 1.0
// ============================================================================
interface malloc_buf_alloc_if
    import malloc_pkg::*;
#(
    parameter int NUM_BUFS = DEF_NUM_BUFS,
    parameter int NUM_CH   = DEF_NUM_CH
);
    localparam int IDX_W = clogb(NUM_BUFS);

    logic [NUM_CH-1:0] alloc_req;
    logic [NUM_CH-1:0] alloc_gnt;
    logic [IDX_W-1:0]  alloc_idx;
    logic              free_valid;
    logic [IDX_W-1:0]  free_idx;
    logic              free_ready;
    logic [IDX_W:0]    free_cnt;
    logic              empty;
    logic              init_done;
    logic              err_double_free;

    modport slave (
        input  alloc_req, free_valid, free_idx,
        output alloc_gnt, alloc_idx, free_ready, free_cnt, empty, init_done,
               err_double_free
    );

    modport master (
        output alloc_req, free_valid, free_idx,
        input  alloc_gnt, alloc_idx, free_ready, free_cnt, empty, init_done,
               err_double_free
    );

endinterface
`default_nettype wire

// File: rtl/malloc_buf_alloc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : malloc_rr_arb
// Description : Round-robin arbiter; priority starts after the last winner.
// Revision    : 1.0
// ============================================================================
module malloc_rr_arb
    import malloc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              adv_i,
    output logic [NUM_CH-1:0] gnt_o
);
    localparam int PTR_W = (NUM_CH > 1) ? clogb(NUM_CH) : 1;

    logic [PTR_W-1:0] prio_q;
    logic [PTR_W-1:0] prio_d;

    always_comb begin
        int   c;
        logic found;
        c      = 0;
        found  = 1'b0;
        gnt_o  = '0;
        prio_d = prio_q;
        for (int i = 0; i < NUM_CH; i++) begin
            c = int'(prio_q) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!found && req_i[c]) begin
                gnt_o[c] = 1'b1;
                found    = 1'b1;
                prio_d   = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= '0;
        end else if (adv_i) begin
            prio_q <= prio_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/malloc_buf_alloc.sv
`default_nettype none
// ============================================================================
// Module      : malloc_buf_alloc
// Description : Bitmap buffer allocator with round-robin multi-channel alloc,
//               valid/ready return port and optional double-free detection
//               (enabled by MALLOC_DOUBLE_FREE_CHK_EN).
// Revision    : 1.0
// ============================================================================
module malloc_buf_alloc
    import malloc_pkg::*;
#(
    parameter int NUM_BUFS   = DEF_NUM_BUFS,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH
) (
    input  logic                clk,
    input  logic                rst,
    malloc_buf_alloc_if.slave   bus
);
    localparam int NUM_WORDS = NUM_BUFS / WORD_WIDTH;
    localparam int IDX_W     = clogb(NUM_BUFS);
    localparam int WADDR_W   = clogb(NUM_WORDS);
    localparam int BIT_W     = clogb(WORD_WIDTH);

    state_t                state_q;
    logic [WADDR_W-1:0]    init_addr_q;
    logic [WADDR_W-1:0]    ptr_q;
    logic [IDX_W-1:0]      fidx_q;
    logic [NUM_CH-1:0]     chan_q;
    logic [NUM_CH-1:0]     alloc_gnt_q;
    logic [IDX_W-1:0]      alloc_idx_q;
    logic [IDX_W:0]        free_cnt_q;
    logic                  init_done_q;
    logic                  err_q;
    logic                  alloc_prio_q;

    logic [WORD_WIDTH-1:0] mem [NUM_WORDS];
    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  mem_we;
    logic [WADDR_W-1:0]    mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;

    logic [NUM_CH-1:0]     eff_req;
    logic [NUM_CH-1:0]     arb_gnt;
    logic                  alloc_ok;
    logic                  free_sel;
    logic                  alloc_sel;
    logic [BIT_W-1:0]      low_bit;
    logic [WORD_WIDTH-1:0] cleared_word;
    logic [WADDR_W-1:0]    free_wa;
    logic [BIT_W-1:0]      free_bit;
    logic [WORD_WIDTH-1:0] set_mask;
    logic                  double_free;

    // The granted channel still holds its request during the grant cycle.
    assign eff_req   = bus.alloc_req & ~alloc_gnt_q;
    assign alloc_ok  = (state_q == ST_IDLE) && (free_cnt_q != '0) && (|eff_req);
    assign free_sel  = (state_q == ST_IDLE) && bus.free_valid && !(alloc_ok && alloc_prio_q);
    assign alloc_sel = alloc_ok && !free_sel;

    malloc_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (eff_req),
        .adv_i (alloc_sel),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        low_bit = '0;
        for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
            if (rdata_q[i]) low_bit = BIT_W'(i);
        end
    end

    assign cleared_word = rdata_q & (rdata_q - {{(WORD_WIDTH-1){1'b0}}, 1'b1});
    assign free_wa      = fidx_q[IDX_W-1:BIT_W];
    assign free_bit     = fidx_q[BIT_W-1:0];
    assign set_mask     = {{(WORD_WIDTH-1){1'b0}}, 1'b1} << free_bit;

`ifdef MALLOC_DOUBLE_FREE_CHK_EN
    assign double_free = |(rdata_q & set_mask);
`else
    assign double_free = 1'b0;
`endif

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = rdata_q;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = init_addr_q;
                mem_wdata = '1;
            end
            ST_ACHK: begin
                mem_we    = |rdata_q;
                mem_wdata = cleared_word;
            end
            ST_FRD: mem_addr = free_wa;
            ST_FWR: begin
                mem_addr  = free_wa;
                mem_we    = !double_free;
                mem_wdata = rdata_q | set_mask;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        rdata_q <= mem[mem_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_addr_q  <= '0;
            ptr_q        <= '0;
            fidx_q       <= '0;
            chan_q       <= '0;
            alloc_gnt_q  <= '0;
            alloc_idx_q  <= '0;
            free_cnt_q   <= (IDX_W+1)'(NUM_BUFS);
            init_done_q  <= 1'b0;
            err_q        <= 1'b0;
            alloc_prio_q <= 1'b0;
        end else begin
            alloc_gnt_q <= '0;
            err_q       <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    init_addr_q <= init_addr_q + 1'b1;
                    if (init_addr_q == WADDR_W'(NUM_WORDS - 1)) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (free_sel) begin
                        fidx_q       <= bus.free_idx;
                        alloc_prio_q <= 1'b0;
                        state_q      <= ST_FRD;
                    end else if (alloc_sel) begin
                        chan_q       <= arb_gnt;
                        alloc_prio_q <= 1'b0;
                        state_q      <= ST_ARD;
                    end
                end
                ST_ARD: state_q <= ST_ACHK;
                ST_ACHK: begin
                    if (|rdata_q) begin
                        alloc_gnt_q <= chan_q;
                        alloc_idx_q <= {ptr_q, low_bit};
                        free_cnt_q  <= free_cnt_q - 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        ptr_q   <= (ptr_q == WADDR_W'(NUM_WORDS - 1)) ? '0 : ptr_q + 1'b1;
                        state_q <= ST_ARD;
                    end
                end
                ST_FRD: state_q <= ST_FWR;
                ST_FWR: begin
                    alloc_prio_q <= 1'b1;
                    state_q      <= ST_IDLE;
                    if (double_free) begin
                        err_q <= 1'b1;
                    end else if (free_cnt_q != (IDX_W+1)'(NUM_BUFS)) begin
                        free_cnt_q <= free_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.alloc_gnt       = alloc_gnt_q;
    assign bus.alloc_idx       = alloc_idx_q;
    assign bus.free_ready      = free_sel;
    assign bus.free_cnt        = free_cnt_q;
    assign bus.empty           = (free_cnt_q == '0);
    assign bus.init_done       = init_done_q;
    assign bus.err_double_free = err_q;

endmodule
`default_nettype wire
